flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_pkg.sv | 8 +
 rtl/flag_stack.sv | 56 +++++
 rtl/flag_unit.sv | 74 +++++++
 tb/tb_flag_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/flag_unit_pkg.sv
// rtl/flag_unit_pkg.sv - shared flag bit indices, widths and defaults for flag_unit
package flag_unit_pkg;
  localparam int FLAG_W            = 3;
  localparam int FLAG_Z            = 0;
  localparam int FLAG_C            = 1;
  localparam int FLAG_N            = 2;
  localparam int STK_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - LIFO flag-save storage with occupancy count and registered full/empty
module flag_stack
  import flag_unit_pkg::*;
#(
  parameter int DEPTH = STK_DEPTH_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [FLAG_W-1:0] i_din,
  output logic [FLAG_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FLAG_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic              r_empty;
  logic              r_full;
  logic [CW-1:0]     w_cnt_nxt;
  logic [AW-1:0]     w_top_idx;

  // Low bits wrap to DEPTH-1 when the stack is full, which is the correct top slot.
  assign w_top_idx = r_count[AW-1:0] - AW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = r_empty;
  assign o_full    = r_full;

  always_comb begin
    w_cnt_nxt = r_count;
    if (i_push)
      w_cnt_nxt = r_count + CW'(1);
    else if (i_pop)
      w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push)
      r_mem[r_count[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - registered Z/C/N flags with ALU update, direct load and save/restore stack
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STK_DEPTH = STK_DEPTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] ALU_RES,
  input  logic              ALU_CARRY,
  input  logic              FLAG_WE,
  input  logic              FLAG_LD,
  input  logic [FLAG_W-1:0] FLAG_IN,
  input  logic              PUSH,
  input  logic              POP,
  output logic [FLAG_W-1:0] FLAG_OUT,
  output logic              STK_EMPTY,
  output logic              STK_FULL,
  output logic              STK_ERR
);
  logic [FLAG_W-1:0] r_flags;
  logic              r_err;
  logic [FLAG_W-1:0] w_alu_flags;
  logic [FLAG_W-1:0] w_top;
  logic              w_empty;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_err;

  assign w_alu_flags[FLAG_Z] = (ALU_RES == '0);
  assign w_alu_flags[FLAG_C] = ALU_CARRY;
  assign w_alu_flags[FLAG_N] = ALU_RES[DATA_W-1];

  // Simultaneous PUSH and POP cancel out: nothing moves and no error is raised.
  assign w_do_push = PUSH & ~POP & ~w_full;
  assign w_do_pop  = POP & ~PUSH & ~w_empty;
  assign w_err     = (PUSH & ~POP & w_full) | (POP & ~PUSH & w_empty);

  flag_stack #(
    .DEPTH (STK_DEPTH)
  ) u_stack (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_do_push),
    .i_pop   (w_do_pop),
    .i_din   (r_flags),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_flags <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_do_pop)
        r_flags <= w_top;
      else if (FLAG_LD)
        r_flags <= FLAG_IN;
      else if (FLAG_WE)
        r_flags <= w_alu_flags;
      if (w_err)
        r_err <= 1'b1;
    end
  end

  assign FLAG_OUT  = r_flags;
  assign STK_EMPTY = w_empty;
  assign STK_FULL  = w_full;
  assign STK_ERR   = r_err;
endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - scoreboard bench for flag_unit driven by hand-computed directed vectors
module tb_flag_unit;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] ALU_RES = '0;
  logic       ALU_CARRY = 1'b0;
  logic       FLAG_WE = 1'b0;
  logic       FLAG_LD = 1'b0;
  logic [2:0] FLAG_IN = '0;
  logic       PUSH = 1'b0;
  logic       POP = 1'b0;
  logic [2:0] FLAG_OUT;
  logic       STK_EMPTY;
  logic       STK_FULL;
  logic       STK_ERR;

  typedef struct {
    logic [2:0] flags;
    logic       empty;
    logic       full;
    logic       err;
    string      name;
  } exp_t;

  exp_t q_exp[$];
  int   total = 0;
  int   bad   = 0;

  flag_unit #(.DATA_W(8), .STK_DEPTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_RES   (ALU_RES),
    .ALU_CARRY (ALU_CARRY),
    .FLAG_WE   (FLAG_WE),
    .FLAG_LD   (FLAG_LD),
    .FLAG_IN   (FLAG_IN),
    .PUSH      (PUSH),
    .POP       (POP),
    .FLAG_OUT  (FLAG_OUT),
    .STK_EMPTY (STK_EMPTY),
    .STK_FULL  (STK_FULL),
    .STK_ERR   (STK_ERR)
  );

  always #5 CLK = ~CLK;

  // Outputs are registered and always present: one expectation is retired per edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (q_exp.size() > 0) begin
        exp_t e;
        e = q_exp.pop_front();
        total++;
        if (FLAG_OUT !== e.flags || STK_EMPTY !== e.empty ||
            STK_FULL !== e.full || STK_ERR !== e.err) begin
          bad++;
          $display("FAIL %s: got flags=%b empty=%b full=%b err=%b, want flags=%b empty=%b full=%b err=%b",
                   e.name, FLAG_OUT, STK_EMPTY, STK_FULL, STK_ERR,
                   e.flags, e.empty, e.full, e.err);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic we, input logic [7:0] res,
                      input logic carry, input logic ld, input logic [2:0] fin,
                      input logic push, input logic pop,
                      input logic [2:0] x_flags, input logic x_empty,
                      input logic x_full, input logic x_err, input string name);
    exp_t e;
    @(negedge CLK);
    RST = rst; FLAG_WE = we; ALU_RES = res; ALU_CARRY = carry;
    FLAG_LD = ld; FLAG_IN = fin; PUSH = push; POP = pop;
    e.flags = x_flags; e.empty = x_empty; e.full = x_full; e.err = x_err; e.name = name;
    q_exp.push_back(e);
  endtask

  initial begin
    //   rst we res    c  ld fin    pu po   flags  e  f  err
    step(1, 0, 8'h00, 0, 0, 3'b000, 0, 0,  3'b000, 1, 0, 0, "reset");
    step(0, 1, 8'h00, 1, 0, 3'b000, 0, 0,  3'b011, 1, 0, 0, "we_zero_carry");
    step(0, 1, 8'h80, 0, 0, 3'b000, 0, 0,  3'b100, 1, 0, 0, "we_negative");
    step(0, 1, 8'h00, 0, 1, 3'b101, 0, 0,  3'b101, 1, 0, 0, "ld_over_we");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 0,  3'b101, 1, 0, 0, "hold");
    step(0, 0, 8'h00, 0, 1, 3'b001, 0, 0,  3'b001, 1, 0, 0, "ld_001");
    step(0, 0, 8'h00, 0, 1, 3'b010, 1, 0,  3'b010, 0, 0, 0, "push_with_ld");
    step(0, 0, 8'h00, 0, 0, 3'b000, 1, 0,  3'b010, 0, 0, 0, "push_2");
    step(0, 0, 8'h00, 0, 1, 3'b100, 0, 0,  3'b100, 0, 0, 0, "ld_100");
    step(0, 1, 8'h01, 1, 0, 3'b000, 0, 1,  3'b010, 0, 0, 0, "pop_over_we");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 1,  3'b001, 1, 0, 0, "pop_to_empty");
    step(0, 0, 8'h00, 0, 1, 3'b010, 1, 0,  3'b010, 0, 0, 0, "fill_1");
    step(0, 0, 8'h00, 0, 1, 3'b101, 1, 1,  3'b101, 0, 0, 0, "push_pop_same");
    step(0, 0, 8'h00, 0, 1, 3'b011, 1, 0,  3'b011, 0, 0, 0, "fill_2");
    step(0, 0, 8'h00, 0, 1, 3'b110, 1, 0,  3'b110, 0, 0, 0, "fill_3");
    step(0, 0, 8'h00, 0, 1, 3'b111, 1, 0,  3'b111, 0, 1, 0, "fill_4_full");
    step(0, 0, 8'h00, 0, 0, 3'b000, 1, 0,  3'b111, 0, 1, 1, "overflow");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 1,  3'b110, 0, 0, 1, "lifo_1");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 1,  3'b011, 0, 0, 1, "lifo_2");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 1,  3'b101, 0, 0, 1, "lifo_3");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 1,  3'b001, 1, 0, 1, "lifo_4");
    step(1, 0, 8'h00, 0, 0, 3'b000, 0, 0,  3'b000, 1, 0, 0, "reset_clears_err");
    step(0, 1, 8'h00, 0, 0, 3'b000, 0, 1,  3'b001, 1, 0, 1, "underflow_we");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 0,  3'b001, 1, 0, 1, "err_sticky");
    step(1, 0, 8'h00, 0, 0, 3'b000, 0, 0,  3'b000, 1, 0, 0, "reset_2");
    step(0, 0, 8'h00, 0, 1, 3'b010, 1, 0,  3'b010, 0, 0, 0, "push_before_rst");
    step(1, 1, 8'h00, 1, 1, 3'b111, 1, 0,  3'b000, 1, 0, 0, "rst_overrides");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 1,  3'b000, 1, 0, 1, "empty_after_rst");
    step(0, 0, 8'h00, 0, 0, 3'b000, 0, 0,  3'b000, 1, 0, 1, "idle");
    @(negedge CLK);
    RST = 1'b0; FLAG_WE = 1'b0; FLAG_LD = 1'b0; PUSH = 1'b0; POP = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
